// File: rtl/ifetch_pkg.sv
// Shared constants and types for the minicpu instruction-fetch stage.
package ifetch_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } state_e;

    // Sequential successor; wraps naturally at 32 bits.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_buf.sv
// One-entry skid buffer holding a fetched word and its address while decode is frozen.
module ifetch_buf (
    input  logic        clk_i,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic [31:0] data_i,
    input  logic [31:0] addr_i,
    output logic        full_o,
    output logic [31:0] data_o,
    output logic [31:0] addr_o
);

    logic        full_q, full_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        addr_d = addr_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
            addr_d = addr_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        full_q <= full_d;
        data_q <= data_d;
        addr_q <= addr_d;
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, delay-slot redirects,
// hazard/SYSCALL freeze of the I1 register toward decode.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int unsigned SYSCALL_STALL = 2
) (
    input  logic        CLK,
    input  logic        MRST,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        instIsSyscall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] I1,
    output logic [31:0] PC1,
    output logic        Valid1
);

    // The detection cycle itself holds, so the counter covers the remaining hold cycles.
    localparam logic [7:0] SysLoad = (SYSCALL_STALL > 0) ? 8'(SYSCALL_STALL - 1) : 8'd0;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] i1_q, i1_d;
    logic [31:0] pc1_q, pc1_d;
    logic        valid1_q, valid1_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [7:0]  sys_cnt_q, sys_cnt_d;
    logic        served_q, served_d;

    logic        buf_full, buf_load, buf_drain;
    logic [31:0] buf_data, buf_addr;
    logic        ack_v, sys_start, hold;

    // Acks with no request in flight (e.g. after reset) are dropped here.
    assign ack_v     = imem_ack && (state_q == StReq);
    assign sys_start = instIsSyscall && !served_q && (SYSCALL_STALL != 0);
    assign hold      = Stall || (sys_cnt_q != 8'd0) || sys_start;

    ifetch_buf u_buf (
        .clk_i   (CLK),
        .flush_i (MRST),
        .load_i  (buf_load),
        .drain_i (buf_drain),
        .data_i  (imem_data),
        .addr_i  (pc_q),
        .full_o  (buf_full),
        .data_o  (buf_data),
        .addr_o  (buf_addr)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        i1_d         = i1_q;
        pc1_d        = pc1_q;
        valid1_d     = valid1_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        sys_cnt_d    = sys_cnt_q;
        served_d     = served_q;
        buf_load     = 1'b0;
        buf_drain    = 1'b0;

        if (Redirect) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = RedirectPC;
        end

        if (ack_v) begin
            if (Redirect) begin
                pc_d         = RedirectPC;
                redir_pend_d = 1'b0;
            end else if (redir_pend_q) begin
                pc_d         = redir_pc_q;
                redir_pend_d = 1'b0;
            end else begin
                pc_d = next_seq_pc(pc_q);
            end
        end

        if (sys_start) begin
            sys_cnt_d = SysLoad;
            served_d  = 1'b1;
        end else if (sys_cnt_q != 8'd0) begin
            sys_cnt_d = sys_cnt_q - 8'd1;
        end

        if (hold) begin
            buf_load = ack_v;
        end else begin
            served_d = 1'b0;
            if (buf_full) begin
                buf_drain = 1'b1;
                i1_d      = buf_data;
                pc1_d     = buf_addr;
                valid1_d  = 1'b1;
            end else if (ack_v) begin
                i1_d     = imem_data;
                pc1_d    = pc_q;
                valid1_d = 1'b1;
            end else begin
                i1_d     = NOP;
                valid1_d = 1'b0;
            end
        end

        unique case (state_q)
            StIdle:  state_d = StReq;
            StReq:   if (ack_v && hold) state_d = StHold;
            StHold:  if (!hold) state_d = StReq;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (MRST) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            i1_q         <= NOP;
            pc1_q        <= RESET_PC;
            valid1_q     <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 32'h0;
            sys_cnt_q    <= 8'd0;
            served_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            i1_q         <= i1_d;
            pc1_q        <= pc1_d;
            valid1_q     <= valid1_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            sys_cnt_q    <= sys_cnt_d;
            served_q     <= served_d;
        end
    end

    assign imem_req  = (state_q == StReq);
    assign imem_addr = pc_q;
    assign I1        = i1_q;
    assign PC1       = pc1_q;
    assign Valid1    = valid1_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: sequential fetch, slow memory, redirects, stall buffer,
// SYSCALL freeze, mid-request reset and PC wrap.
module tb_ifetch;

    logic        CLK = 1'b0;
    logic        MRST, Stall, Redirect, instIsSyscall, imem_ack;
    logic [31:0] RedirectPC, imem_data;
    logic        imem_req, Valid1;
    logic [31:0] imem_addr, I1, PC1;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] Base    = 32'h0040_0000;
    localparam logic [31:0] Syscall = 32'h0000_000C;

    ifetch dut (
        .CLK           (CLK),
        .MRST          (MRST),
        .Stall         (Stall),
        .Redirect      (Redirect),
        .RedirectPC    (RedirectPC),
        .instIsSyscall (instIsSyscall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .I1            (I1),
        .PC1           (PC1),
        .Valid1        (Valid1)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_i1(input string tag, input logic [31:0] i1, input logic [31:0] pc1,
                            input logic v);
        check({tag, ".I1"}, I1, i1);
        check({tag, ".PC1"}, PC1, pc1);
        check({tag, ".Valid1"}, {31'b0, Valid1}, {31'b0, v});
    endtask

    initial begin
        MRST = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        instIsSyscall = 1'b0; imem_ack = 1'b0; imem_data = '0;
        tick();
        check("rst.req", {31'b0, imem_req}, 32'd0);
        check("rst.addr", imem_addr, Base);
        check_i1("rst", 32'h0, Base, 1'b0);
        MRST = 1'b0;
        tick();
        check("idle2req", {31'b0, imem_req}, 32'd1);

        // Ack every cycle
        for (int k = 0; k < 4; k++) begin
            check("seq.addr", imem_addr, Base + 32'(4 * k));
            imem_ack = 1'b1; imem_data = mem(Base + 32'(4 * k));
            tick();
            check_i1("seq", mem(Base + 32'(4 * k)), Base + 32'(4 * k), 1'b1);
        end

        // Slow memory with a redirect latched while waiting on 0x400010
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Redirect = (i == 1); RedirectPC = 32'h0040_0100;
            tick();
            check("wait.addr", imem_addr, Base + 32'h10);
            check("wait.req", {31'b0, imem_req}, 32'd1);
            check_i1("wait", 32'h0, Base + 32'hC, 1'b0);
        end
        Redirect = 1'b0;
        imem_ack = 1'b1; imem_data = mem(Base + 32'h10);
        tick();
        check_i1("dslot", mem(Base + 32'h10), Base + 32'h10, 1'b1);
        check("redir.addr", imem_addr, 32'h0040_0100);

        // Redirect coinciding with ack
        Redirect = 1'b1; RedirectPC = 32'h0040_0200; imem_data = mem(32'h0040_0100);
        tick();
        Redirect = 1'b0;
        check_i1("redir2", mem(32'h0040_0100), 32'h0040_0100, 1'b1);
        check("redir2.addr", imem_addr, 32'h0040_0200);

        // Stall 4 cycles, ack in the first
        Stall = 1'b1; imem_data = mem(32'h0040_0200);
        for (int i = 0; i < 4; i++) begin
            tick();
            imem_ack = 1'b0;
            check_i1("stall", mem(32'h0040_0100), 32'h0040_0100, 1'b1);
            check("stall.req", {31'b0, imem_req}, 32'd0);
        end
        Stall = 1'b0;
        tick();
        check_i1("drain", mem(32'h0040_0200), 32'h0040_0200, 1'b1);
        check("drain.req", {31'b0, imem_req}, 32'd1);
        check("drain.addr", imem_addr, 32'h0040_0204);

        // SYSCALL freeze: visible 1 + 2 hold cycles; an extra Stall must not retrigger
        imem_ack = 1'b1; imem_data = Syscall;
        tick();
        check_i1("sys.load", Syscall, 32'h0040_0204, 1'b1);
        instIsSyscall = 1'b1; imem_data = mem(32'h0040_0208);
        tick();
        imem_ack = 1'b0;
        check_i1("sys.h1", Syscall, 32'h0040_0204, 1'b1);
        check("sys.req", {31'b0, imem_req}, 32'd0);
        tick();
        check_i1("sys.h2", Syscall, 32'h0040_0204, 1'b1);
        Stall = 1'b1;
        tick();
        check_i1("sys.extstall", Syscall, 32'h0040_0204, 1'b1);
        Stall = 1'b0;
        tick();
        instIsSyscall = 1'b0;
        check_i1("sys.resume", mem(32'h0040_0208), 32'h0040_0208, 1'b1);
        check("sys.addr", imem_addr, 32'h0040_020C);
        check("sys.req2", {31'b0, imem_req}, 32'd1);

        // Reset while a request is outstanding; late ack ignored
        tick();
        MRST = 1'b1;
        tick();
        MRST = 1'b0;
        check("mrst.req", {31'b0, imem_req}, 32'd0);
        check("mrst.addr", imem_addr, Base);
        check_i1("mrst", 32'h0, Base, 1'b0);
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        tick();
        check_i1("late", 32'h0, Base, 1'b0);
        check("late.req", {31'b0, imem_req}, 32'd1);
        check("late.addr", imem_addr, Base);
        imem_data = mem(Base);
        tick();
        check_i1("restart", mem(Base), Base, 1'b1);

        // PC wrap at the top of the address space
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC; imem_data = mem(Base + 32'h4);
        tick();
        Redirect = 1'b0;
        check("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
        imem_data = mem(32'hFFFF_FFFC);
        tick();
        imem_ack = 1'b0;
        check_i1("wrap", mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1);
        check("wrap.addr1", imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
